// File: rtl/uart_pkt_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_parser_pkg
// Description : Shared state encoding, error codes and default sync marker
//               for the UART packet parser.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkt_parser_pkg;

    // Parser state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CMD     = ST_CMD,
        S_LEN     = ST_LEN,
        S_PAYLOAD = ST_PAYLOAD,
        S_CHK     = ST_CHK,
        S_HOLD    = ST_HOLD
    } state_e;

    // Error codes reported with err_valid
    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    // Default frame start marker
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/uart_pkt_parser_pkt_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : pkt_buf_ram
// Description : DEPTH x 8 payload buffer, one write port, registered read.
//               Storage has no reset so it maps onto distributed/block RAM;
//               only the read register is cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_buf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, one cycle latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/uart_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_parser
// Description : Assembles SYNC/CMD/LEN/payload/CHK frames from UART byte
//               strobes, holds a good packet behind a valid/ack handshake and
//               reports dropped frames with a one-cycle error strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pkt_parser
    import uart_pkt_parser_pkg::*;
#(
    parameter int         CLK_FREQ    = 50000000,
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = CLK_FREQ / 1000,
    localparam int        LW          = $clog2(MAX_LEN + 1),
    localparam int        AW          = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          pkt_valid,
    input  logic          pkt_ack,
    output logic [7:0]    pkt_cmd,
    output logic [LW-1:0] pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_valid,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    C_MAX_LEN  = 8'(MAX_LEN);

    state_e        state_q;
    logic [7:0]    cmd_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [7:0]    chk_q;
    logic [TW-1:0] tmo_q;
    logic          pkt_valid_q;
    logic [7:0]    pkt_cmd_q;
    logic [LW-1:0] pkt_len_q;
    logic          err_valid_q;
    logic [1:0]    err_code_q;
    logic          busy_q;

    // Payload bytes go straight to the buffer; nothing writes it outside
    // PAYLOAD, so the held packet stays frozen in HOLD.
    logic w_buf_we;
    assign w_buf_we = in_valid && (state_q == S_PAYLOAD);

    pkt_buf_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_buf_we),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Frame parser FSM with inter-byte timeout and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= 8'h00;
            tmo_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_cmd_q   <= 8'h00;
            pkt_len_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            err_valid_q <= 1'b0;
            if (state_q == S_HOLD) begin
                tmo_q <= '0;
                if (pkt_ack) begin
                    // Release wins; a coincident byte is judged as in IDLE
                    pkt_valid_q <= 1'b0;
                    if (in_valid && (in_data == SYNC_BYTE)) begin
                        state_q <= S_CMD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end else if (in_valid) begin
                    err_valid_q <= 1'b1;
                    err_code_q  <= ERR_OVR;
                end
            end else if (in_valid) begin
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state_q <= S_CMD;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        cmd_q   <= in_data;
                        chk_q   <= in_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        if (in_data > C_MAX_LEN) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            len_q   <= in_data[LW-1:0];
                            chk_q   <= chk_q ^ in_data;
                            idx_q   <= '0;
                            state_q <= (in_data == 8'h00) ? S_CHK : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        chk_q <= chk_q ^ in_data;
                        idx_q <= idx_q + LW'(1);
                        if (idx_q == (len_q - LW'(1))) begin
                            state_q <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (in_data == chk_q) begin
                            state_q     <= S_HOLD;
                            pkt_valid_q <= 1'b1;
                            pkt_cmd_q   <= cmd_q;
                            pkt_len_q   <= len_q;
                        end else begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (state_q != S_IDLE) begin
                // Silent cycle inside a frame; the byte-wins case is above
                if (tmo_q == C_TMO_LAST) begin
                    err_valid_q <= 1'b1;
                    err_code_q  <= ERR_TMO;
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_cmd   = pkt_cmd_q;
    assign pkt_len   = pkt_len_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_pkt_parser
// Description : Self-checking bench for uart_pkt_parser with an event
//               scoreboard for packet and error outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_pkt_parser;
    import uart_pkt_parser_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;
    localparam int LW      = 5;
    localparam int AW      = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          pkt_ack  = 1'b0;
    logic [AW-1:0] rd_addr  = '0;
    logic          pkt_valid;
    logic [7:0]    pkt_cmd;
    logic [LW-1:0] pkt_len;
    logic [7:0]    rd_data;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          busy;

    always #5 clk = ~clk;

    uart_pkt_parser #(
        .CLK_FREQ    (50000000),
        .SYNC_BYTE   (8'hAA),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .pkt_valid (pkt_valid),
        .pkt_ack   (pkt_ack),
        .pkt_cmd   (pkt_cmd),
        .pkt_len   (pkt_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .err_valid (err_valid),
        .err_code  (err_code),
        .busy      (busy)
    );

    typedef struct packed {
        logic          is_err;
        logic [1:0]    code;
        logic [7:0]    cmd;
        logic [LW-1:0] len;
    } exp_t;

    exp_t       sb_q [$];
    exp_t       mon_e;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] pl     [MAX_LEN];
    logic [7:0] exp_pl [MAX_LEN];
    logic       pv_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every error pulse and every pkt_valid rise pops one entry
    always @(negedge clk) begin
        if (!rst) begin
            pv_prev = 1'b0;
        end else begin
            if (err_valid) begin
                check_eq("sb_have_exp_err", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check_eq("sb_kind_err", 32'(mon_e.is_err), 32'd1);
                    check_eq("sb_err_code", 32'(err_code), 32'(mon_e.code));
                end
            end
            if (pkt_valid && !pv_prev) begin
                check_eq("sb_have_exp_pkt", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check_eq("sb_kind_pkt", 32'(mon_e.is_err), 32'd0);
                    check_eq("sb_pkt_cmd", 32'(pkt_cmd), 32'(mon_e.cmd));
                    check_eq("sb_pkt_len", 32'(pkt_len), 32'(mon_e.len));
                end
            end
            pv_prev = pkt_valid;
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
    endtask

    task automatic push_err(input logic [1:0] code);
        sb_q.push_back('{is_err: 1'b1, code: code, cmd: 8'h00, len: '0});
    endtask

    task automatic push_pkt(input logic [7:0] cmd, input int len);
        sb_q.push_back('{is_err: 1'b0, code: 2'd0, cmd: cmd, len: LW'(len)});
    endtask

    // Full frame from pl[]; bad corrupts the checksum byte
    task automatic send_frame(input logic [7:0] cmd, input int len, input logic bad);
        logic [7:0] c;
        c = cmd ^ 8'(len);
        for (int i = 0; i < len; i++) c = c ^ pl[i];
        if (bad) begin
            c = c ^ 8'h07;
            push_err(ERR_CHK);
        end else begin
            push_pkt(cmd, len);
            for (int i = 0; i < len; i++) exp_pl[i] = pl[i];
        end
        send(8'hAA);
        send(cmd);
        send(8'(len));
        for (int i = 0; i < len; i++) send(pl[i]);
        send(c);
    endtask

    task automatic read_chk(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            @(posedge clk);
            #1;
            check_eq("rd_data", 32'(rd_data), 32'(exp_pl[i]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
        check_eq({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
        check_eq({tag, "_pkt_cmd"},   32'(pkt_cmd),   32'd0);
        check_eq({tag, "_pkt_len"},   32'(pkt_len),   32'd0);
        check_eq({tag, "_rd_data"},   32'(rd_data),   32'd0);
        check_eq({tag, "_err_code"},  32'(err_code),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        idle(1);

        // Good packet AA 01 02 10 20 33
        pl[0] = 8'h10; pl[1] = 8'h20;
        send_frame(8'h01, 2, 1'b0);
        check_eq("good_pkt_valid", 32'(pkt_valid), 32'd1);
        check_eq("good_pkt_cmd", 32'(pkt_cmd), 32'h01);
        check_eq("good_pkt_len", 32'(pkt_len), 32'd2);
        check_eq("good_busy", 32'(busy), 32'd1);
        read_chk(2);
        ack();
        check_eq("ack_pkt_valid", 32'(pkt_valid), 32'd0);
        check_eq("ack_busy", 32'(busy), 32'd0);

        // Bad checksum AA 01 02 10 20 34
        send_frame(8'h01, 2, 1'b1);
        check_eq("badchk_err_valid", 32'(err_valid), 32'd1);
        check_eq("badchk_err_code", 32'(err_code), 32'(ERR_CHK));
        idle(1);
        check_eq("badchk_pulse_width", 32'(err_valid), 32'd0);
        check_eq("badchk_busy", 32'(busy), 32'd0);
        check_eq("badchk_pkt_valid", 32'(pkt_valid), 32'd0);

        // LEN above MAX_LEN
        push_err(ERR_LEN);
        send(8'hAA); send(8'h05); send(8'h11);
        check_eq("len_err_code", 32'(err_code), 32'(ERR_LEN));
        check_eq("len_err_busy", 32'(busy), 32'd0);

        // LEN exactly MAX_LEN
        for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'(i * 7 + 1);
        send_frame(8'h3C, MAX_LEN, 1'b0);
        check_eq("maxlen_pkt_len", 32'(pkt_len), 32'(MAX_LEN));
        read_chk(MAX_LEN);
        ack();

        // LEN = 0: AA 07 00 07
        send_frame(8'h07, 0, 1'b0);
        check_eq("len0_pkt_valid", 32'(pkt_valid), 32'd1);
        check_eq("len0_pkt_len", 32'(pkt_len), 32'd0);
        ack();

        // Timeout after AA 01 and TMO silent cycles
        push_err(ERR_TMO);
        send(8'hAA); send(8'h01);
        idle(TMO - 1);
        check_eq("tmo_early_err", 32'(err_valid), 32'd0);
        check_eq("tmo_early_busy", 32'(busy), 32'd1);
        idle(1);
        check_eq("tmo_err_valid", 32'(err_valid), 32'd1);
        check_eq("tmo_err_code", 32'(err_code), 32'(ERR_TMO));
        check_eq("tmo_busy", 32'(busy), 32'd0);

        // Every byte lands exactly on the timeout boundary cycle
        push_pkt(8'h01, 2);
        exp_pl[0] = 8'h10; exp_pl[1] = 8'h20;
        send(8'hAA);
        send(8'h01); idle(TMO - 1);
        send(8'h02); idle(TMO - 1);
        send(8'h10); idle(TMO - 1);
        send(8'h20); idle(TMO - 1);
        send(8'h33);
        check_eq("bound_pkt_valid", 32'(pkt_valid), 32'd1);
        read_chk(2);
        ack();

        // Overrun in HOLD leaves the held packet intact
        pl[0] = 8'h5A;
        send_frame(8'h03, 1, 1'b0);
        push_err(ERR_OVR);
        send(8'h55);
        check_eq("ovr_err_valid", 32'(err_valid), 32'd1);
        check_eq("ovr_err_code", 32'(err_code), 32'(ERR_OVR));
        check_eq("ovr_pkt_valid", 32'(pkt_valid), 32'd1);
        check_eq("ovr_pkt_cmd", 32'(pkt_cmd), 32'h03);
        check_eq("ovr_pkt_len", 32'(pkt_len), 32'd1);
        read_chk(1);

        // Ack coincident with SYNC starts the next frame immediately
        push_pkt(8'h02, 1);
        in_valid = 1'b1; in_data = 8'hAA; pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; pkt_ack = 1'b0;
        check_eq("coinc_busy", 32'(busy), 32'd1);
        check_eq("coinc_pkt_valid", 32'(pkt_valid), 32'd0);
        check_eq("coinc_err_valid", 32'(err_valid), 32'd0);
        exp_pl[0] = 8'h7F;
        send(8'h02); send(8'h01); send(8'h7F); send(8'h7C);
        check_eq("coinc_pkt_cmd", 32'(pkt_cmd), 32'h02);
        read_chk(1);
        ack();

        // Asynchronous reset in the middle of PAYLOAD
        send(8'hAA); send(8'h04); send(8'h03); send(8'h11); send(8'h22);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        pl[0] = 8'hC3;
        send_frame(8'h09, 1, 1'b0);
        check_eq("postrst_pkt_cmd", 32'(pkt_cmd), 32'h09);
        read_chk(1);
        ack();

        idle(3);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
